// File: rtl/vedic_nxn_pipelined.sv
// vedic_nxn_pipelined: parametrised, fully pipelined N x N Vedic (Urdhva-Tiryagbhyam)
// multiplier. Level 1 forms every 2x2 cell product. Each further level merges groups of
// four sub-products into one product of twice the width. Every level is registered.
// A valid/ready handshake stalls the whole pipe when the output is held.
// Optional signed mode: define VEDIC_SIGNED_EN. This adds the sgn port, a magnitude input
// stage and sign restoration in the final stage.
module vedic_nxn_pipelined #(
    parameter int WIDTH = 8
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   i,
    input  logic [WIDTH-1:0]   j,
`ifdef VEDIC_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z
);
    localparam int LVL = $clog2(WIDTH);
`ifdef VEDIC_SIGNED_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    localparam int LAT = LVL + OFF;

    // 2x2 Vedic cell: vertical and crosswise partial products with the carry folded in
    function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
        logic       c1;
        logic [3:0] p;
        p[0] = a[0] & b[0];
        p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c1   = (a[1] & b[0]) & (a[0] & b[1]);
        p[2] = (a[1] & b[1]) ^ c1;
        p[3] = (a[1] & b[1]) & c1;
        return p;
    endfunction

    logic           stall_s;
    logic [LAT:1]   vld_d;
    logic [LAT:1]   vld_q;
    logic [LAT:1]   ld_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;

    // A held output freezes every stage; otherwise each stage loads only a valid beat,
    // so a bubble leaves stale data (and z) untouched.
    assign stall_s   = vld_q[LAT] & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = vld_q[LAT];
    assign ld_s      = {LAT{~stall_s}} & {vld_q[LAT-1:1], in_valid};

    // Valid bits shift one stage per moving cycle and hold while stalled
    always_comb begin
        vld_d = vld_q;
        if (!stall_s) begin
            vld_d = {vld_q[LAT-1:1], in_valid};
        end else begin
            vld_d = vld_q;
        end
    end

    // Valid-bit register; reset discards every in-flight beat
    always_ff @(posedge clk1) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

`ifdef VEDIC_SIGNED_EN
    logic [WIDTH-1:0] ia_d, ia_q, ja_d, ja_q;
    logic [LAT-1:1]   neg_d, neg_q;

    // Input stage takes operand magnitudes; the product sign then rides along with its beat
    always_comb begin
        ia_d  = ia_q;
        ja_d  = ja_q;
        neg_d = neg_q;
        if (ld_s[1]) begin
            ia_d     = (sgn && i[WIDTH-1]) ? (~i + {{(WIDTH-1){1'b0}}, 1'b1}) : i;
            ja_d     = (sgn && j[WIDTH-1]) ? (~j + {{(WIDTH-1){1'b0}}, 1'b1}) : j;
            neg_d[1] = sgn & (i[WIDTH-1] ^ j[WIDTH-1]);
        end else begin
            neg_d[1] = neg_q[1];
        end
        for (int s = 2; s < LAT; s++) begin
            if (ld_s[s]) begin
                neg_d[s] = neg_q[s-1];
            end else begin
                neg_d[s] = neg_q[s];
            end
        end
    end

    // Magnitude and sign registers
    always_ff @(posedge clk1) begin
        if (rst) begin
            ia_q  <= '0;
            ja_q  <= '0;
            neg_q <= '0;
        end else begin
            ia_q  <= ia_d;
            ja_q  <= ja_d;
            neg_q <= neg_d;
        end
    end

    assign a_s = ia_q;
    assign b_s = ja_q;
`else
    assign a_s = i;
    assign b_s = j;
`endif

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int B  = 2 ** k;      // operand chunk width at this level
        localparam int N  = WIDTH / B;   // chunks per operand
        localparam int PW = 2 * B;       // sub-product width
        localparam int ST = k + OFF;     // pipeline stage holding this level
        logic [N*N*PW-1:0] c_s;
        logic [N*N*PW-1:0] res_s;
        logic [N*N*PW-1:0] p_d;
        logic [N*N*PW-1:0] p_q;

        if (k == 1) begin : g_leaf
            // One 2x2 cell per (multiplicand pair r, multiplier pair c)
            always_comb begin
                c_s = '0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        c_s[(r*N+c)*PW +: PW] = vedic2x2(a_s[2*r +: 2], b_s[2*c +: 2]);
                    end
                end
            end
        end else begin : g_node
            localparam int H = B / 2;
            logic [B-1:0] ll_s, lh_s, hl_s, hh_s;
            logic [B:0]   cr_s;
            // Combine: LL + ((LH + HL) << h) + (HH << 2h); the cross sum keeps its carry bit
            always_comb begin
                c_s  = '0;
                ll_s = '0;
                lh_s = '0;
                hl_s = '0;
                hh_s = '0;
                cr_s = '0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        ll_s = g_lvl[k-1].p_q[((2*r)*(2*N) + 2*c)*B +: B];
                        lh_s = g_lvl[k-1].p_q[((2*r)*(2*N) + 2*c+1)*B +: B];
                        hl_s = g_lvl[k-1].p_q[((2*r+1)*(2*N) + 2*c)*B +: B];
                        hh_s = g_lvl[k-1].p_q[((2*r+1)*(2*N) + 2*c+1)*B +: B];
                        cr_s = {1'b0, lh_s} + {1'b0, hl_s};
                        c_s[(r*N+c)*PW +: PW] = (PW)'(ll_s) + ((PW)'(cr_s) << H) + {hh_s, {B{1'b0}}};
                    end
                end
            end
        end

        if (k == LVL) begin : g_last
`ifdef VEDIC_SIGNED_EN
            // Final stage re-applies the product sign carried with the beat
            always_comb begin
                if (neg_q[LAT-1]) begin
                    res_s = ~c_s + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    res_s = c_s;
                end
            end
`else
            assign res_s = c_s;
`endif
        end else begin : g_mid
            assign res_s = c_s;
        end

        // Load a valid moving beat, otherwise hold
        always_comb begin
            if (ld_s[ST]) begin
                p_d = res_s;
            end else begin
                p_d = p_q;
            end
        end

        // Level register
        always_ff @(posedge clk1) begin
            if (rst) begin
                p_q <= '0;
            end else begin
                p_q <= p_d;
            end
        end
    end

    assign z = g_lvl[LVL].p_q;

endmodule

// File: tb/tb_vedic_nxn_pipelined.sv
// Bench for vedic_nxn_pipelined: four instances (WIDTH 4, 8, 16, 32) share handshake
// stimulus. Each instance has a queue model that checks outputs every cycle. Directed
// literal checks pin the model's expected values.
module tb_vedic_nxn_pipelined;
`ifdef VEDIC_SIGNED_EN
    localparam int SOFF = 1;
`else
    localparam int SOFF = 0;
`endif
    localparam int NW = 4;

    logic        clk1      = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        sgn_in    = 1'b0;
    logic        do_drain  = 1'b0;
    logic [31:0] opa       = 32'd0;
    logic [31:0] opb       = 32'd0;
    int          n_pass    = 0;
    int          n_total   = 0;

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < NW; g++) begin : g_w
        localparam int W = 4 << g;
        localparam int L = $clog2(W) + SOFF;
        logic           in_ready;
        logic           out_valid;
        logic [2*W-1:0] z;
        logic [63:0]    q_val [$];
        int             q_rem [$];
        logic [63:0]    last_z = 64'd0;
        bit             armed  = 1'b0;

        vedic_nxn_pipelined #(.WIDTH(W)) u_dut (
            .clk1     (clk1),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .i        (opa[W-1:0]),
            .j        (opb[W-1:0]),
`ifdef VEDIC_SIGNED_EN
            .sgn      (sgn_in),
`endif
            .out_valid(out_valid),
            .out_ready(out_ready),
            .z        (z)
        );

        function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                                   input logic s);
            logic [63:0] ea;
            logic [63:0] eb;
            logic [63:0] p;
            ea = 64'(a[W-1:0]);
            eb = 64'(b[W-1:0]);
            if (s && a[W-1]) ea = ea - (64'd1 << W);
            if (s && b[W-1]) eb = eb - (64'd1 << W);
            p = ea * eb;
            if (W < 32) p = p & ((64'd1 << (2*W)) - 64'd1);
            return p;
        endfunction

        // Compare outputs with the model, then advance the model across the next edge
        always @(negedge clk1) begin
            bit mov;
            bit mstall;
            mov    = (q_rem.size() > 0) && (q_rem[0] == 0);
            mstall = mov && !out_ready;
            if (armed) begin
                check($sformatf("w%0d out_valid", W), 64'(out_valid), 64'(mov));
                check($sformatf("w%0d in_ready", W), 64'(in_ready), 64'(!mstall));
                check($sformatf("w%0d z", W), 64'(z), mov ? q_val[0] : last_z);
            end
            if (do_drain) begin
                check($sformatf("w%0d drained", W), 64'(q_val.size()), 64'd0);
            end
            if (rst) begin
                q_val.delete();
                q_rem.delete();
                last_z = 64'd0;
                armed  = 1'b1;
            end else if (!mstall) begin
                if (mov) begin
                    last_z = q_val.pop_front();
                    void'(q_rem.pop_front());
                end
                foreach (q_rem[k]) begin
                    if (q_rem[k] > 0) q_rem[k] = q_rem[k] - 1;
                end
                if (in_valid) begin
                    q_val.push_back(model_prod(opa, opb, sgn_in));
                    q_rem.push_back(L - 1);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk1);
        #1;
        in_valid = v;
        opa      = a;
        opb      = b;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        check("w8 reset out_valid", 64'(g_w[1].out_valid), 64'd0);
        check("w8 reset z", 64'(g_w[1].z), 64'd0);
        check("w8 reset in_ready", 64'(g_w[1].in_ready), 64'd1);

        // Basic products back to back
        out_ready = 1'b1;
        drive(1'b1, 32'd0, 32'd0);
        drive(1'b1, 32'd1, 32'd1);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(1'b1, 32'd170, 32'd204);
        repeat (SOFF) drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 0x0 valid", 64'(g_w[1].out_valid), 64'd1);
        check("w8 0x0", 64'(g_w[1].z), 64'd0);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 1x1", 64'(g_w[1].z), 64'd1);
        check("w4 15x15", 64'(g_w[0].z), 64'd225);
        check("w4 15x15 valid", 64'(g_w[0].out_valid), 64'd1);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 255x255", 64'(g_w[1].z), 64'd65025);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 170x204", 64'(g_w[1].z), 64'd34680);
        check("w8 170x204 valid", 64'(g_w[1].out_valid), 64'd1);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w32 ones squared", 64'(g_w[3].z), 64'hFFFF_FFFE_0000_0001);
        check("w8 bubble valid", 64'(g_w[1].out_valid), 64'd0);
        check("w8 bubble holds z", 64'(g_w[1].z), 64'd34680);

        // Stall retention with three beats in flight
        drive(1'b1, 32'd15, 32'd30);
        out_ready = 1'b0;
        drive(1'b1, 32'd25, 32'd40);
        drive(1'b1, 32'd50, 32'd60);
        repeat (SOFF) drive(1'b0, 32'd0, 32'd0);
        for (int t = 0; t < 10; t++) begin
            drive(1'b0, 32'd0, 32'd0);
            @(negedge clk1);
            check("w8 stall z", 64'(g_w[1].z), 64'd450);
            check("w8 stall in_ready", 64'(g_w[1].in_ready), 64'd0);
        end
        drive(1'b0, 32'd0, 32'd0);
        out_ready = 1'b1;
        @(negedge clk1);
        check("w8 release 450", 64'(g_w[1].z), 64'd450);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 release 1000", 64'(g_w[1].z), 64'd1000);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 release 3000", 64'(g_w[1].z), 64'd3000);

`ifdef VEDIC_SIGNED_EN
        // Signed products, latency 4 at WIDTH 8
        drive(1'b1, 32'h80, 32'h80);
        sgn_in = 1'b1;
        drive(1'b1, 32'hFF, 32'h7F);
        drive(1'b1, 32'h64, 32'hFD);
        drive(1'b1, 32'hFF, 32'hFF);
        sgn_in = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 s -128x-128", 64'(g_w[1].z), 64'd16384);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 s -1x127", 64'(g_w[1].z), 64'hFF81);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 s 100x-3", 64'(g_w[1].z), 64'hFED4);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk1);
        check("w8 u 255x255", 64'(g_w[1].z), 64'd65025);
`endif

        // Reset mid-flight: three accepted beats must vanish
        drive(1'b1, 32'd1234, 32'd5678);
        drive(1'b1, 32'd42, 32'd99);
        drive(1'b1, 32'd7, 32'd9);
        drive(1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk1);
        check("w16 reset out_valid", 64'(g_w[2].out_valid), 64'd0);
        check("w16 reset z", 64'(g_w[2].z), 64'd0);
        check("w32 reset z", 64'(g_w[3].z), 64'd0);
        repeat (8) drive(1'b0, 32'd0, 32'd0);

        // Random stream with random backpressure
        for (int t = 0; t < 1500; t++) begin
            drive(($urandom_range(0, 3) != 0), $urandom(), $urandom());
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef VEDIC_SIGNED_EN
            sgn_in = $urandom_range(0, 1) != 0;
`endif
        end

        // Drain and confirm every accepted beat came out
        drive(1'b0, 32'd0, 32'd0);
        out_ready = 1'b1;
        repeat (12) drive(1'b0, 32'd0, 32'd0);
        @(posedge clk1);
        #1 do_drain = 1'b1;
        @(posedge clk1);
        #1 do_drain = 1'b0;
        @(negedge clk1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
